// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every requester handshake and the shared RAM word port that
//   mem_port_arbiter sequences. The clock and reset stay plain module ports.
//
//   Signals
//     vid_req/vid_addr/vid_ack                  video refresh fetch (read only)
//     cpu_req/cpu_we/cpu_wtbt/cpu_addr/cpu_din  CPU bus request
//     cpu_ack                                   CPU completion pulse
//     cp_req/cp_we/cp_addr/cp_din/cp_ack        host mem_copy engine
//     rd_data                                   data of the last completed read
//     grant                                     owner: 0 video, 1 cpu, 2 copy, 3 refresh
//     ram_addr/ram_din/ram_wtbt                 port address, write data, byte enables
//     ram_we/ram_rd/ram_ref                     one-cycle port strobes
//     ram_dout                                  port read data
//
//   Modports
//     slave  : the arbiter itself
//     master : the surroundings (requesters plus the RAM model)
interface mem_port_arbiter_if;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;

  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_wtbt;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_ack;

  logic        cp_req;
  logic        cp_we;
  logic [23:0] cp_addr;
  logic [15:0] cp_din;
  logic        cp_ack;

  logic [15:0] rd_data;
  logic [1:0]  grant;

  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_wtbt;
  logic        ram_we;
  logic        ram_rd;
  logic        ram_ref;
  logic [15:0] ram_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_wtbt, cpu_addr, cpu_din,
    input  cp_req, cp_we, cp_addr, cp_din,
    input  ram_dout,
    output vid_ack, cpu_ack, cp_ack,
    output rd_data, grant,
    output ram_addr, ram_din, ram_wtbt, ram_we, ram_rd, ram_ref
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_wtbt, cpu_addr, cpu_din,
    output cp_req, cp_we, cp_addr, cp_din,
    output ram_dout,
    input  vid_ack, cpu_ack, cp_ack,
    input  rd_data, grant,
    input  ram_addr, ram_din, ram_wtbt, ram_we, ram_rd, ram_ref
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single SDRAM-backed word port between video fetch, the CPU
//   bus and the mem_copy engine, one access at a time with a fixed port
//   latency. Priority is video > CPU > copy; copy is promoted above the CPU
//   after STARVE_MAX consecutive CPU grants taken while copy was waiting.
//
//   Ports
//     clk_ram  memory clock, all state on the rising edge
//     reset_n  asynchronous active-low reset
//     bus      mem_port_arbiter_if.slave (requesters + RAM port)
//
//   Parameters
//     LAT         strobe-to-data / write-retire latency in cycles (1..15)
//     STARVE_MAX  CPU grants tolerated while copy waits (1..15)
//     REF_PERIOD  cycles between refresh requests (refresh build only)
//
//   Build option
//     MEMARB_REFRESH_EN  adds a periodic refresh owner (grant = 3) served
//                        ahead of all requesters at the next IDLE. Without
//                        it ram_ref is tied low and grant never reaches 3.
module mem_port_arbiter #(
  parameter int LAT        = 4,
  parameter int STARVE_MAX = 3,
  parameter int REF_PERIOD = 780
) (
  input  logic              clk_ram,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  if (LAT < 1 || LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15 || REF_PERIOD < 2) begin : gParamCheck
    $error("mem_port_arbiter: parameter out of range");
  end

  localparam logic [1:0] OWN_VID  = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_CP   = 2'd2;
  localparam logic [3:0] LAT_L    = 4'(LAT);
  localparam logic [3:0] STARVE_L = 4'(STARVE_MAX);

`ifdef MEMARB_REFRESH_EN
  localparam logic [1:0] OWN_REF = 2'd3;
  localparam int         REF_W   = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_REFRESH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;
`endif

  state_t      r_state;
  state_t      w_nextState;

  logic [1:0]  r_grant;
  logic [23:0] r_addr;
  logic [15:0] r_din;
  logic [1:0]  r_wtbt;
  logic        r_we;
  logic [3:0]  r_waitCnt;
  logic [3:0]  r_starveCnt;
  logic [15:0] r_rdData;

  logic        w_win;
  logic [1:0]  w_winOwner;
  logic [23:0] w_winAddr;
  logic [15:0] w_winDin;
  logic [1:0]  w_winWtbt;
  logic        w_winWe;
  logic        w_starveFull;
  logic        w_waitLast;
  logic        w_issue;
  logic        w_done;
  logic        w_accept;

`ifdef MEMARB_REFRESH_EN
  logic [REF_W-1:0] r_refCnt;
  logic             r_refDue;
  logic             w_isRef;

  assign w_isRef = (r_grant == OWN_REF);
`endif

  assign w_starveFull = (r_starveCnt == STARVE_L);
  assign w_waitLast   = (r_waitCnt == 4'd1);
  assign w_issue      = (r_state == S_ISSUE);
  assign w_done       = (r_state == S_DONE);
  assign w_accept     = (r_state == S_IDLE) && w_win;

  // Winner selection, evaluated every cycle but only acted on in IDLE.
  // Copy jumps ahead of the CPU once the starvation counter is full, and
  // otherwise only wins when the CPU is not asking. Video is never held
  // back by the guard. A refresh winner keeps the old port attributes.
  always_comb begin
    w_win      = 1'b1;
    w_winOwner = OWN_VID;
    w_winAddr  = r_addr;
    w_winDin   = r_din;
    w_winWtbt  = r_wtbt;
    w_winWe    = 1'b0;
`ifdef MEMARB_REFRESH_EN
    if (r_refDue) begin
      w_winOwner = OWN_REF;
    end else
`endif
    if (bus.vid_req) begin
      w_winOwner = OWN_VID;
      w_winAddr  = bus.vid_addr;
      w_winWtbt  = 2'b11;
      w_winWe    = 1'b0;
    end else if (bus.cp_req && (w_starveFull || !bus.cpu_req)) begin
      w_winOwner = OWN_CP;
      w_winAddr  = bus.cp_addr;
      w_winDin   = bus.cp_din;
      w_winWtbt  = 2'b11;
      w_winWe    = bus.cp_we;
    end else if (bus.cpu_req) begin
      w_winOwner = OWN_CPU;
      w_winAddr  = bus.cpu_addr;
      w_winDin   = bus.cpu_din;
      w_winWtbt  = bus.cpu_wtbt;
      w_winWe    = bus.cpu_we;
    end else begin
      w_win = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> WAIT (LAT cycles) -> DONE -> IDLE.
  // A refresh takes ISSUE for its strobe and then waits in REFRESH.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_win) begin
          w_nextState = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef MEMARB_REFRESH_EN
        w_nextState = w_isRef ? S_REFRESH : S_WAIT;
`else
        w_nextState = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (w_waitLast) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
`ifdef MEMARB_REFRESH_EN
      S_REFRESH: begin
        if (w_waitLast) begin
          w_nextState = S_IDLE;
        end
      end
`endif
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Access registers: the winner's attributes are frozen on acceptance so
  // the port stays stable through DONE even if the requester misbehaves.
  // The wait counter is loaded in ISSUE and runs down to zero; the last
  // WAIT cycle is the one where it reads 1, which is also when ram_dout
  // becomes valid and is captured.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_grant   <= OWN_VID;
      r_addr    <= '0;
      r_din     <= '0;
      r_wtbt    <= '0;
      r_we      <= 1'b0;
      r_waitCnt <= '0;
      r_rdData  <= '0;
    end else begin
      if (w_accept) begin
        r_grant <= w_winOwner;
        r_addr  <= w_winAddr;
        r_din   <= w_winDin;
        r_wtbt  <= w_winWtbt;
        r_we    <= w_winWe;
      end
      if (w_issue) begin
        r_waitCnt <= LAT_L;
      end else if (r_waitCnt != 4'd0) begin
        r_waitCnt <= r_waitCnt - 4'd1;
      end
      if ((r_state == S_WAIT) && w_waitLast && !r_we) begin
        r_rdData <= bus.ram_dout;
      end
    end
  end

  // Starvation guard: counts CPU grants taken while copy was waiting,
  // saturating at STARVE_MAX, and restarts whenever copy gets the port.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_starveCnt <= '0;
    end else if (w_accept) begin
      if (w_winOwner == OWN_CP) begin
        r_starveCnt <= '0;
      end else if ((w_winOwner == OWN_CPU) && bus.cp_req && !w_starveFull) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
    end
  end

`ifdef MEMARB_REFRESH_EN
  // Free-running refresh timer. An expiry that lands while a refresh is
  // already pending merges into it; a new expiry wins over a clear in the
  // same cycle so it is never lost.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_refCnt <= '0;
      r_refDue <= 1'b0;
    end else begin
      if (r_refCnt == REF_W'(REF_PERIOD - 1)) begin
        r_refCnt <= '0;
        r_refDue <= 1'b1;
      end else begin
        r_refCnt <= r_refCnt + REF_W'(1);
        if (w_accept && (w_winOwner == OWN_REF)) begin
          r_refDue <= 1'b0;
        end
      end
    end
  end

  assign bus.ram_rd  = w_issue & ~r_we & ~w_isRef;
  assign bus.ram_ref = w_issue & w_isRef;
`else
  assign bus.ram_rd  = w_issue & ~r_we;
  assign bus.ram_ref = 1'b0;
`endif

  assign bus.ram_we   = w_issue & r_we;
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_din;
  assign bus.ram_wtbt = r_wtbt;

  assign bus.vid_ack  = w_done & (r_grant == OWN_VID);
  assign bus.cpu_ack  = w_done & (r_grant == OWN_CPU);
  assign bus.cp_ack   = w_done & (r_grant == OWN_CP);

  assign bus.rd_data  = r_rdData;
  assign bus.grant    = r_grant;

endmodule
